// File: rtl/regfile_mp_if.sv
// Register-file access bus: read addresses and data for NUM_RD ports, plus two
// byte-enabled write ports. The decode/writeback side is the master.
interface regfile_mp_if #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5,
  parameter int NUM_RD = 2
);
  logic [NUM_RD*ADDR_W-1:0] RegRdAddr;
  logic [NUM_RD*DATA_W-1:0] RegRdData;

  logic [ADDR_W-1:0]   RegWrAddrA;
  logic [DATA_W-1:0]   RegWrDataA;
  logic [DATA_W/8-1:0] RegWrBeA;
  logic                RegWriteA;

  logic [ADDR_W-1:0]   RegWrAddrB;
  logic [DATA_W-1:0]   RegWrDataB;
  logic [DATA_W/8-1:0] RegWrBeB;
  logic                RegWriteB;

  modport master (
    output RegRdAddr,
    input  RegRdData,
    output RegWrAddrA, RegWrDataA, RegWrBeA, RegWriteA,
    output RegWrAddrB, RegWrDataB, RegWrBeB, RegWriteB
  );

  modport slave (
    input  RegRdAddr,
    output RegRdData,
    input  RegWrAddrA, RegWrDataA, RegWrBeA, RegWriteA,
    input  RegWrAddrB, RegWrDataB, RegWrBeB, RegWriteB
  );
endinterface

// File: rtl/regfile_mp.sv
// Parametrised multi-port register file: NUM_RD read ports, two byte-enabled
// write ports (B wins per lane), optional zero register, bypass and read register.
module regfile_mp #(
  parameter int DATA_W   = 32,
  parameter int ADDR_W   = 5,
  parameter int NUM_RD   = 2,
  parameter bit ZERO_REG = 1'b1,
  parameter bit BYPASS   = 1'b1,
  parameter bit RD_REG   = 1'b0
) (
  input logic         Clk,
  input logic         Rst_n,
  regfile_mp_if.slave rf
);

  localparam int DEPTH = 2**ADDR_W;
  localparam int LANES = DATA_W / 8;

  typedef logic [DATA_W-1:0] word_t;

  word_t mem [DEPTH];

  logic  wrValidA;
  logic  wrValidB;
  logic  sameAddr;
  word_t newA;
  word_t newB;
  word_t rdNext [NUM_RD];
  word_t rdOut  [NUM_RD];

  function automatic word_t laneMerge(input word_t old, input word_t data,
                                      input logic [LANES-1:0] be);
    word_t res;
    res = old;
    for (int k = 0; k < LANES; k++) begin
      if (be[k]) res[k*8 +: 8] = data[k*8 +: 8];
    end
    return res;
  endfunction

  // Writes are gated by reset so a write presented while in reset is neither
  // stored nor forwarded to the read ports.
  always_comb begin
    wrValidA = rf.RegWriteA && Rst_n && !(ZERO_REG && (rf.RegWrAddrA == '0));
    wrValidB = rf.RegWriteB && Rst_n && !(ZERO_REG && (rf.RegWrAddrB == '0));
    sameAddr = wrValidA && (rf.RegWrAddrA == rf.RegWrAddrB);
    newA     = laneMerge(mem[rf.RegWrAddrA], rf.RegWrDataA, rf.RegWrBeA);
    // On a shared address B merges on top of A, giving B priority per lane.
    newB     = laneMerge(sameAddr ? newA : mem[rf.RegWrAddrB], rf.RegWrDataB, rf.RegWrBeB);
  end

  // NOTE: the whole array sits in the async reset so no register can ever
  // read X; this keeps the storage in flops rather than a RAM macro.
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      for (int r = 0; r < DEPTH; r++) mem[r] <= '0;
    end else begin
      // NOTE: non-blocking updates; when both ports hit one address the later
      // B assignment lands last and already carries A's lanes.
      if (wrValidA) mem[rf.RegWrAddrA] <= newA;
      if (wrValidB) mem[rf.RegWrAddrB] <= newB;
    end
  end

  // Read path: array lookup, optional forwarding of this cycle's write, then
  // the zero-register override which takes precedence over forwarding.
  always_comb begin
    logic [ADDR_W-1:0] rdAddr;
    rdAddr = '0;
    for (int i = 0; i < NUM_RD; i++) begin
      rdAddr    = rf.RegRdAddr[i*ADDR_W +: ADDR_W];
      rdNext[i] = mem[rdAddr];
      if (BYPASS) begin
        if (wrValidB && (rdAddr == rf.RegWrAddrB))      rdNext[i] = newB;
        else if (wrValidA && (rdAddr == rf.RegWrAddrA)) rdNext[i] = newA;
      end
      if (ZERO_REG && (rdAddr == '0)) rdNext[i] = '0;
    end
  end

  generate
    if (RD_REG) begin : gRdReg
      always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
          for (int i = 0; i < NUM_RD; i++) rdOut[i] <= '0;
        end else begin
          for (int i = 0; i < NUM_RD; i++) rdOut[i] <= rdNext[i];
        end
      end
    end else begin : gRdComb
      always_comb begin
        for (int i = 0; i < NUM_RD; i++) rdOut[i] = rdNext[i];
      end
    end
  endgenerate

  always_comb begin
    rf.RegRdData = '0;
    for (int i = 0; i < NUM_RD; i++) rf.RegRdData[i*DATA_W +: DATA_W] = rdOut[i];
  end

endmodule

// File: tb/tb_regfile_mp.sv
// Bench for regfile_mp: three instances (bypass/comb, no-bypass/comb,
// bypass/registered) driven identically and checked against an array model.
module tb_regfile_mp;

  logic Clk   = 1'b0;
  logic Rst_n = 1'b0;
  always #5 Clk = ~Clk;

  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifComb ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifNoByp ();
  regfile_mp_if #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2)) ifReg ();

  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b0))
    dutComb (.Clk(Clk), .Rst_n(Rst_n), .rf(ifComb.slave));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b0), .RD_REG(1'b0))
    dutNoByp (.Clk(Clk), .Rst_n(Rst_n), .rf(ifNoByp.slave));
  regfile_mp #(.DATA_W(32), .ADDR_W(5), .NUM_RD(2), .ZERO_REG(1'b1), .BYPASS(1'b1), .RD_REG(1'b1))
    dutReg (.Clk(Clk), .Rst_n(Rst_n), .rf(ifReg.slave));

  typedef struct {
    logic [4:0]  rd0, rd1;
    logic        wA;
    logic [4:0]  aA;
    logic [31:0] dA;
    logic [3:0]  beA;
    logic        wB;
    logic [4:0]  aB;
    logic [31:0] dB;
    logic [3:0]  beB;
    logic [31:0] exp0, exp1;   // bypassing combinational read, same cycle
  } vec_t;

  int nChecks = 0;
  int nFail   = 0;

  logic [31:0] model [32];
  logic [4:0]  curRd0, curRd1, curAA, curAB;
  logic        curWA, curWB;
  logic [31:0] curDA, curDB;
  logic [3:0]  curBeA, curBeB;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    nChecks++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] data,
                                        input logic [3:0] be);
    logic [31:0] mask;
    mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
    return (old & ~mask) | (data & mask);
  endfunction

  task automatic drive(input logic [4:0] r0, input logic [4:0] r1,
                       input logic wA, input logic [4:0] aA, input logic [31:0] dA, input logic [3:0] beA,
                       input logic wB, input logic [4:0] aB, input logic [31:0] dB, input logic [3:0] beB);
    curRd0 = r0; curRd1 = r1;
    curWA = wA; curAA = aA; curDA = dA; curBeA = beA;
    curWB = wB; curAB = aB; curDB = dB; curBeB = beB;
    ifComb.RegRdAddr = {r1, r0};  ifNoByp.RegRdAddr = {r1, r0};  ifReg.RegRdAddr = {r1, r0};
    ifComb.RegWriteA = wA;  ifNoByp.RegWriteA = wA;  ifReg.RegWriteA = wA;
    ifComb.RegWrAddrA = aA; ifNoByp.RegWrAddrA = aA; ifReg.RegWrAddrA = aA;
    ifComb.RegWrDataA = dA; ifNoByp.RegWrDataA = dA; ifReg.RegWrDataA = dA;
    ifComb.RegWrBeA = beA;  ifNoByp.RegWrBeA = beA;  ifReg.RegWrBeA = beA;
    ifComb.RegWriteB = wB;  ifNoByp.RegWriteB = wB;  ifReg.RegWriteB = wB;
    ifComb.RegWrAddrB = aB; ifNoByp.RegWrAddrB = aB; ifReg.RegWrAddrB = aB;
    ifComb.RegWrDataB = dB; ifNoByp.RegWrDataB = dB; ifReg.RegWrDataB = dB;
    ifComb.RegWrBeB = beB;  ifNoByp.RegWrBeB = beB;  ifReg.RegWrBeB = beB;
  endtask

  task automatic driveIdle(input logic [4:0] r0, input logic [4:0] r1);
    drive(r0, r1, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 4'h0);
  endtask

  // Called at posedge+1 with inputs applied; returns at the next posedge+1.
  task automatic cycle(input string tag, input bit useTab, input logic [31:0] t0, input logic [31:0] t1);
    logic [31:0] nxt [32];
    logic [31:0] expReg0, expReg1;
    nxt = model;
    if (curWA && curAA != 5'd0) nxt[curAA] = merge(nxt[curAA], curDA, curBeA);
    if (curWB && curAB != 5'd0) nxt[curAB] = merge(nxt[curAB], curDB, curBeB);
    @(negedge Clk);
    check({tag, " byp rd0"},   ifComb.RegRdData[31:0],   nxt[curRd0]);
    check({tag, " byp rd1"},   ifComb.RegRdData[63:32],  nxt[curRd1]);
    check({tag, " nobyp rd0"}, ifNoByp.RegRdData[31:0],  model[curRd0]);
    check({tag, " nobyp rd1"}, ifNoByp.RegRdData[63:32], model[curRd1]);
    if (useTab) begin
      check({tag, " table rd0"}, ifComb.RegRdData[31:0],  t0);
      check({tag, " table rd1"}, ifComb.RegRdData[63:32], t1);
    end
    expReg0 = nxt[curRd0];
    expReg1 = nxt[curRd1];
    @(posedge Clk);
    #1;
    model = nxt;
    check({tag, " reg rd0"}, ifReg.RegRdData[31:0],  expReg0);
    check({tag, " reg rd1"}, ifReg.RegRdData[63:32], expReg1);
  endtask

  task automatic checkAllZero(input string tag);
    check({tag, " byp rd0"},   ifComb.RegRdData[31:0],   32'h0);
    check({tag, " byp rd1"},   ifComb.RegRdData[63:32],  32'h0);
    check({tag, " nobyp rd0"}, ifNoByp.RegRdData[31:0],  32'h0);
    check({tag, " nobyp rd1"}, ifNoByp.RegRdData[63:32], 32'h0);
    check({tag, " reg rd0"},   ifReg.RegRdData[31:0],    32'h0);
    check({tag, " reg rd1"},   ifReg.RegRdData[63:32],   32'h0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [9];
    vecs[0] = '{5'd5, 5'd7, 1'b1, 5'd5, 32'hDEADBEEF, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{5'd5, 5'd5, 1'b0, 5'd0, 32'h0, 4'h0, 1'b1, 5'd5, 32'h00000011, 4'h1, 32'hDEADBE11, 32'hDEADBE11};
    vecs[2] = '{5'd7, 5'd5, 1'b1, 5'd7, 32'hAAAAAAAA, 4'hF, 1'b1, 5'd7, 32'hBBBBBBBB, 4'h3, 32'hAAAABBBB, 32'hDEADBE11};
    vecs[3] = '{5'd3, 5'd4, 1'b1, 5'd3, 32'h33333333, 4'hF, 1'b1, 5'd4, 32'h44444444, 4'hF, 32'h33333333, 32'h44444444};
    vecs[4] = '{5'd0, 5'd3, 1'b1, 5'd0, 32'h12345678, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0, 32'h0, 32'h33333333};
    vecs[5] = '{5'd9, 5'd9, 1'b1, 5'd9, 32'h00000055, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0, 32'h55, 32'h55};
    vecs[6] = '{5'd9, 5'd7, 1'b0, 5'd0, 32'h0, 4'h0, 1'b0, 5'd0, 32'h0, 4'h0, 32'h55, 32'hAAAABBBB};
    vecs[7] = '{5'd4, 5'd0, 1'b1, 5'd4, 32'hFFFFFFFF, 4'h0, 1'b1, 5'd0, 32'h9, 4'hF, 32'h44444444, 32'h0};
    vecs[8] = '{5'd4, 5'd6, 1'b1, 5'd4, 32'hCAFEF00D, 4'hA, 1'b0, 5'd0, 32'h0, 4'h0, 32'hCA44F044, 32'h0};

    for (int r = 0; r < 32; r++) model[r] = 32'h0;

    // Reset and defaults
    driveIdle(5'd0, 5'd0);
    @(posedge Clk);
    #1;
    checkAllZero("reset");
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    for (int a = 0; a < 32; a++) begin
      driveIdle(5'(a), 5'(31 - a));
      cycle("defaults", 1'b0, 32'h0, 32'h0);
    end

    // Directed vectors: byte enables, collisions, zero register, bypass
    for (int v = 0; v < 9; v++) begin
      drive(vecs[v].rd0, vecs[v].rd1, vecs[v].wA, vecs[v].aA, vecs[v].dA, vecs[v].beA,
            vecs[v].wB, vecs[v].aB, vecs[v].dB, vecs[v].beB);
      cycle($sformatf("vec%0d", v), 1'b1, vecs[v].exp0, vecs[v].exp1);
    end

    // Randomised traffic over a narrow address window to force collisions
    for (int n = 0; n < 400; n++) begin
      logic [4:0] aA, aB, r0, r1;
      aA = 5'($urandom_range(0, 7));
      aB = ($urandom_range(0, 2) == 0) ? aA : 5'($urandom_range(0, 7));
      r0 = ($urandom_range(0, 1) == 0) ? aA : 5'($urandom_range(0, 31));
      r1 = ($urandom_range(0, 1) == 0) ? aB : 5'($urandom_range(0, 7));
      drive(r0, r1, ($urandom_range(0, 3) != 0), aA, $urandom, 4'($urandom),
            ($urandom_range(0, 3) != 0), aB, $urandom, 4'($urandom));
      cycle("random", 1'b0, 32'h0, 32'h0);
    end

    // Async reset between edges, with a write presented during reset
    drive(5'd2, 5'd2, 1'b1, 5'd2, 32'h1, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0);
    cycle("pre-reset", 1'b0, 32'h0, 32'h0);
    drive(5'd2, 5'd2, 1'b1, 5'd2, 32'h77, 4'hF, 1'b0, 5'd0, 32'h0, 4'h0);
    #2;
    Rst_n = 1'b0;
    #1;
    for (int r = 0; r < 32; r++) model[r] = 32'h0;
    checkAllZero("async reset");
    @(posedge Clk);
    #1;
    checkAllZero("write in reset");
    driveIdle(5'd2, 5'd2);
    #2;
    Rst_n = 1'b1;
    @(posedge Clk);
    #1;
    cycle("post-reset", 1'b0, 32'h0, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule

// File: doc/regfile_mp.md
Name: regfile_mp

Overview:
- Parametrised multi-port general-purpose register file. Successor to the fixed 32x32, 2-read/1-write CPU register file.
- Adds the following:
  - configurable width, depth and read-port count
  - a second write port
  - byte-lane write enables
  - optional register-0 hardwiring
  - write-to-read bypass
  - optional registered (1-cycle) read path
- Sits between the decode stage (read addresses) and the writeback stage (writes) of the CPU datapath.

Parameters:
- DATA_W, 32: register width in bits; must be a multiple of 8.
- ADDR_W, 5: address width; depth = 2**ADDR_W.
- NUM_RD, 2: number of read ports, 1..4.
- ZERO_REG, 1: 1 means register 0 reads as 0 and ignores writes.
- BYPASS, 1: 1 means a same-cycle write to a read address is forwarded to the read data.
- RD_REG, 0: 0 gives combinational read data; 1 gives read data registered (1-cycle latency).

Ports:
- Clk, in, 1: clock; all state updates on the rising edge.
- Rst_n, in, 1: asynchronous active-low reset.
- RegRdAddr, in, NUM_RD*ADDR_W: read addresses; port i is bits [i*ADDR_W +: ADDR_W].
- RegRdData, out, NUM_RD*DATA_W: read data; port i is bits [i*DATA_W +: DATA_W].
- RegWrAddrA, in, ADDR_W: write port A address.
- RegWrDataA, in, DATA_W: write port A data.
- RegWrBeA, in, DATA_W/8: write port A byte enables.
- RegWriteA, in, 1: write port A enable.
- RegWrAddrB, in, ADDR_W: write port B address.
- RegWrDataB, in, DATA_W: write port B data.
- RegWrBeB, in, DATA_W/8: write port B byte enables.
- RegWriteB, in, 1: write port B enable.

Behaviour:
- Reset:
  - Rst_n low asynchronously clears all 2**ADDR_W registers to 0.
  - If RD_REG=1, it also clears the RegRdData output registers to 0.
  - Reset asserted mid-write: the write is lost and the register stays 0.
  - Deassertion is synchronised externally; the first write is accepted on the first rising edge with Rst_n high.
- Write:
  - On a rising edge with RegWriteX=1, byte lane k of register RegWrAddrX is loaded from RegWrDataX lane k wherever RegWrBeX[k]=1.
  - Unenabled lanes keep their value. RegWriteX=1 with all byte enables 0 is a no-op.
- Write collision:
  - Both ports write the same address: merge is per lane; port B wins on lanes enabled by both, port A applies on lanes only it enables.
  - Different addresses: both writes commit in the same cycle.
- Zero register (ZERO_REG=1): writes to address 0 are discarded by either port. Reads of address 0 return 0 regardless of bypass.
- Read, RD_REG=0:
  - RegRdData[i] = mem[RegRdAddr[i]] combinationally, zero-cycle latency.
  - With BYPASS=1, if RegRdAddr[i] matches an address being written this cycle, return the post-edge merged value (A/B lane priority as above). This gives write-then-read-same-cycle semantics.
  - With BYPASS=0, return the old value until the edge.
- Read, RD_REG=1:
  - RegRdData[i] is registered on the rising edge, 1-cycle latency.
  - With BYPASS=1, the captured value includes the same-edge write (new data). With BYPASS=0, it is the pre-write value.
- Read ports are independent; any number may share an address.
- Out-of-range addresses cannot occur (full 2**ADDR_W decode).
- No X may propagate from unwritten registers; reset guarantees all registers are 0.

Test Plan:
1. Reset and read, defaults: Rst_n=0 then 1; read all 32 addresses on both ports -> all read 0.
2. Single write, byte enables: A writes reg5 with 0xDEADBEEF, Be=4'b1111; next cycle B writes reg5 with 0x00000011, Be=4'b0001 -> reg5 reads 0xDEADBE11.
3. Collision:
   - A writes reg7=0xAAAAAAAA with Be=4'b1111; B writes reg7=0xBBBBBBBB with Be=4'b0011, same edge -> reg7=0xAAAABBBB.
   - Separately, A and B write reg3 and reg4 in the same cycle -> both commit.
4. Zero register: A writes reg0=0x12345678 -> reg0 still reads 0, including a same-cycle read with BYPASS=1.
5. Bypass and registered read:
   - BYPASS=1, RD_REG=0: write reg9=0x55 while reading reg9 -> RegRdData shows 0x55 in the same cycle.
   - BYPASS=0: shows the old value, then 0x55 next cycle.
   - RD_REG=1, BYPASS=1: output is 0x55 one cycle after the address is presented.
6. Async reset mid-operation: write reg2=0x1; pulse Rst_n low between clock edges with no Clk edge -> reg2 and RegRdData read 0 immediately; a write presented during reset is ignored.
